// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the dot-matrix Tetris engine.
package tetris_pkg;

    localparam int unsigned COLS_DEF = 8;
    localparam int unsigned ROWS_DEF = 16;
    localparam int unsigned CELLS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

    // Flat playfield bit index of cell (x, y); y grows downward.
    function automatic int unsigned bit_idx(input int unsigned x,
                                            input int unsigned y,
                                            input int unsigned cols);
        return x + y * cols;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; holds at all nines.
module bcd_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   value
);

    logic [4*DIGITS-1:0] cnt_q;
    logic [4*DIGITS-1:0] cnt_d;
    logic                all_nine;
    logic                carry;

    // Ripple a +1 through the digits unless already saturated.
    always_comb begin
        cnt_d    = cnt_q;
        all_nine = 1'b1;
        carry    = 1'b0;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (cnt_q[4*d +: 4] != 4'd9) begin
                all_nine = 1'b0;
            end
        end
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !all_nine) begin
            carry = 1'b1;
            for (int unsigned d = 0; d < DIGITS; d++) begin
                if (carry) begin
                    if (cnt_q[4*d +: 4] == 4'd9) begin
                        cnt_d[4*d +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*d +: 4] = cnt_q[4*d +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/drop_lock_engine.sv
// Gravity step, piece lock and sequential line-clear engine owning the playfield.
module drop_lock_engine
    import tetris_pkg::*;
#(
    parameter int unsigned COLS   = COLS_DEF,
    parameter int unsigned ROWS   = ROWS_DEF,
    parameter int unsigned XW     = 3,
    parameter int unsigned YW     = 4,
    parameter int unsigned DIGITS = 4
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   step,
    input  logic                   clr_map,
    input  logic [CELLS*XW-1:0]    blk_x,
    input  logic [CELLS*YW-1:0]    blk_y,
    output logic [CELLS*YW-1:0]    new_y,
    output logic                   moved,
    output logic                   placed,
    output logic                   busy,
    output logic [COLS*ROWS-1:0]   map,
    output logic [2:0]             clr_cnt,
    output logic [4*DIGITS-1:0]    lines,
    output logic                   top_out
);

    localparam int unsigned MAPW = COLS * ROWS;
    localparam int unsigned IW   = (MAPW > 1) ? $clog2(MAPW) : 1;

    state_e                state_q, state_d;
    logic [MAPW-1:0]       map_q, map_d;
    logic [CELLS*YW-1:0]   new_y_q, new_y_d;
    logic [CELLS*XW-1:0]   px_q, px_d;
    logic [CELLS*YW-1:0]   py_q, py_d;
    logic [YW-1:0]         row_q, row_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            clr_cnt_q, clr_cnt_d;
    logic                  moved_q, moved_d;
    logic                  placed_q, placed_d;
    logic                  busy_q, busy_d;
    logic                  top_out_q, top_out_d;

    logic                  collide_c;
    logic                  line_inc_c;
    logic [COLS-1:0]       row_bits_c;
    logic                  row_full_c;
    logic [MAPW-1:0]       lower_c;
    logic [MAPW-1:0]       upper_c;
    logic [MAPW-1:0]       shifted_c;

    // A cell collides on the floor, on a filled cell below it, or when off the field.
    always_comb begin
        collide_c = 1'b0;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (32'(blk_x[i*XW +: XW]) >= COLS || 32'(blk_y[i*YW +: YW]) >= ROWS - 1) begin
                collide_c = 1'b1;
            end else if (map_q[IW'(bit_idx(32'(blk_x[i*XW +: XW]),
                                           32'(blk_y[i*YW +: YW]) + 32'd1, COLS))]) begin
                collide_c = 1'b1;
            end
        end
    end

    // Row under the scan pointer: fullness test and the map with that row removed.
    always_comb begin
        row_bits_c = COLS'(map_q >> (32'(row_q) * COLS));
        row_full_c = &row_bits_c;
        lower_c    = (MAPW'(1) << (32'(row_q) * COLS)) - MAPW'(1);
        upper_c    = ~((MAPW'(1) << ((32'(row_q) + 32'd1) * COLS)) - MAPW'(1));
        shifted_c  = (map_q & upper_c) | ((map_q & lower_c) << COLS);
    end

    // Next-state and output logic for the drop / lock / scan sequence.
    always_comb begin
        state_d    = state_q;
        map_d      = map_q;
        new_y_d    = new_y_q;
        px_d       = px_q;
        py_d       = py_q;
        row_d      = row_q;
        cnt_d      = cnt_q;
        clr_cnt_d  = clr_cnt_q;
        moved_d    = 1'b0;
        placed_d   = 1'b0;
        busy_d     = busy_q;
        top_out_d  = top_out_q;
        line_inc_c = 1'b0;

        if (clr_map) begin
            state_d   = IDLE;
            map_d     = '0;
            clr_cnt_d = '0;
            top_out_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step) begin
                        if (collide_c) begin
                            state_d = LOCK;
                            busy_d  = 1'b1;
                            px_d    = blk_x;
                            py_d    = blk_y;
                        end else begin
                            moved_d = 1'b1;
                            for (int unsigned i = 0; i < CELLS; i++) begin
                                new_y_d[i*YW +: YW] = blk_y[i*YW +: YW] + YW'(1);
                            end
                        end
                    end
                end
                LOCK: begin
                    for (int unsigned i = 0; i < CELLS; i++) begin
                        if (32'(px_q[i*XW +: XW]) < COLS && 32'(py_q[i*YW +: YW]) < ROWS) begin
                            map_d[IW'(bit_idx(32'(px_q[i*XW +: XW]),
                                              32'(py_q[i*YW +: YW]), COLS))] = 1'b1;
                        end
                        if (py_q[i*YW +: YW] == '0) begin
                            top_out_d = 1'b1;
                        end
                    end
                    row_d   = YW'(ROWS - 1);
                    cnt_d   = '0;
                    state_d = SCAN;
                end
                SCAN: begin
                    if (row_full_c) begin
                        map_d      = shifted_c;
                        cnt_d      = cnt_q + 3'd1;
                        line_inc_c = 1'b1;
                    end else if (row_q == '0) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q - YW'(1);
                    end
                end
                DONE: begin
                    clr_cnt_d = cnt_q;
                    placed_d  = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            map_q     <= '0;
            new_y_q   <= '0;
            px_q      <= '0;
            py_q      <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            clr_cnt_q <= '0;
            moved_q   <= 1'b0;
            placed_q  <= 1'b0;
            busy_q    <= 1'b0;
            top_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            map_q     <= map_d;
            new_y_q   <= new_y_d;
            px_q      <= px_d;
            py_q      <= py_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            clr_cnt_q <= clr_cnt_d;
            moved_q   <= moved_d;
            placed_q  <= placed_d;
            busy_q    <= busy_d;
            top_out_q <= top_out_d;
        end
    end

    bcd_counter #(
        .DIGITS (DIGITS)
    ) u_lines (
        .CLK   (CLK),
        .reset (reset),
        .clr   (clr_map),
        .inc   (line_inc_c),
        .value (lines)
    );

    assign new_y   = new_y_q;
    assign moved   = moved_q;
    assign placed  = placed_q;
    assign busy    = busy_q;
    assign map     = map_q;
    assign clr_cnt = clr_cnt_q;
    assign top_out = top_out_q;

endmodule
